// File: rtl/cordic_result_serializer.sv
// Captures CORDIC results on the rising edge of done, queues them in a small FIFO and
// streams them MSB-first over a valid/ready serial link. Define PARITY_EN for a trailing even-parity bit.
module cordic_result_serializer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         res_val,
    input  logic                     res_done,
    input  logic                     ser_ready,
    input  logic                     clear_ovf,
    output logic                     ser_data,
    output logic                     ser_valid,
    output logic                     ser_frame,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WM1 = WIDTH - 1;
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
    localparam logic [BW-1:0] TOP_CNT = WM1[BW-1:0];

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_next;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_next;
    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     bit_cnt;
    logic              done_q;
    logic              push, push_ok, drop, load, advance;
`ifdef PARITY_EN
    logic              par;
`endif

    // A full FIFO still accepts a push when the serializer pops at the same edge.
    assign push    = res_done & ~done_q;
    assign push_ok = push & (~full | load);
    assign drop    = push & ~push_ok;

    always_comb begin
        count_next = count;
        case ({push_ok, load})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= res_val;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q   <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            done_q <= res_done;
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (load)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);
            if (drop)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (load) begin
                shreg   <= mem[rd_ptr];
                bit_cnt <= TOP_CNT;
`ifdef PARITY_EN
                par     <= ^mem[rd_ptr];
`endif
            end else if (advance) begin
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt - BW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        ser_valid  = 1'b0;
        ser_data   = 1'b0;
        ser_frame  = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_data  = shreg[WIDTH-1];
                ser_frame = (bit_cnt == TOP_CNT);
                if (ser_ready) begin
                    advance = 1'b1;
                    if (bit_cnt == '0)
`ifdef PARITY_EN
                        state_next = PARITY;
`else
                        state_next = IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                ser_valid = 1'b1;
                ser_data  = par;
                if (ser_ready)
                    state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cordic_result_serializer.sv
// Self-checking bench for cordic_result_serializer: vector table plus hand-written corner sequences,
// with a serial-side monitor that reassembles frames and compares them against a scoreboard queue.
module tb_cordic_result_serializer;
    localparam int WIDTH = 11;
    localparam int DEPTH = 4;
`ifdef PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    typedef struct {
        logic [WIDTH-1:0] val;
        logic             par;
    } vec_t;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] res_val;
    logic             res_done;
    logic             ser_ready;
    logic             clear_ovf;
    logic             ser_data;
    logic             ser_valid;
    logic             ser_frame;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t sb[$];
    vec_t tbl[7];

    int               mon_idx     = 0;
    int               frames_seen = 0;
    int               cyc         = 0;
    int               last_end    = 0;
    int               last_gap    = 0;
    logic [WIDTH-1:0] mon_bits;
    logic             mon_par;

    cordic_result_serializer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .res_val  (res_val),
        .res_done (res_done),
        .ser_ready(ser_ready),
        .clear_ovf(clear_ovf),
        .ser_data (ser_data),
        .ser_valid(ser_valid),
        .ser_frame(ser_frame),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic [WIDTH-1:0] v, input bit accepted);
        vec_t e;
        e.val = v;
        e.par = ^v;
        res_val  = v;
        res_done = 1'b1;
        if (accepted)
            sb.push_back(e);
        tick();
        res_done = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || mon_idx != 0 || ser_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    // Serial-side monitor: sampled on the falling edge, counts bits accepted at the next rising edge.
    always @(negedge clock) begin
        vec_t exp_v;
        cyc++;
        if (reset) begin
            mon_idx = 0;
        end else if (ser_valid && ser_ready) begin
            check("frame_flag", 32'(ser_frame), 32'(mon_idx == 0));
            if (mon_idx == 0)
                last_gap = cyc - last_end;
            if (mon_idx < WIDTH)
                mon_bits[WIDTH-1-mon_idx] = ser_data;
            else
                mon_par = ser_data;
            mon_idx++;
            if (mon_idx == FL) begin
                frames_seen++;
                mon_idx  = 0;
                last_end = cyc;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got %0h, expected no frame", mon_bits);
                end else begin
                    exp_v = sb.pop_front();
                    check("frame_data", 32'(mon_bits), 32'(exp_v.val));
`ifdef PARITY_EN
                    check("frame_parity", 32'(mon_par), 32'(exp_v.par));
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        int n;
        logic [WIDTH-1:0] v;

        tbl[0] = '{val: 11'b00100110000, par: 1'b1};
        tbl[1] = '{val: 11'h7FF,         par: 1'b1};
        tbl[2] = '{val: 11'h000,         par: 1'b0};
        tbl[3] = '{val: 11'h555,         par: 1'b0};
        tbl[4] = '{val: 11'h001,         par: 1'b1};
        tbl[5] = '{val: 11'h400,         par: 1'b1};
        tbl[6] = '{val: 11'h3C3,         par: 1'b0};

        reset     = 1'b1;
        res_done  = 1'b0;
        res_val   = '0;
        ser_ready = 1'b1;
        clear_ovf = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(ser_valid), 0);
        check("rst_data", 32'(ser_data), 0);
        check("rst_frame", 32'(ser_frame), 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;
        repeat (2) tick();

        // Single frames: push-to-first-bit latency and full frame content.
        for (int i = 0; i < 7; i++) begin
            res_val  = tbl[i].val;
            res_done = 1'b1;
            sb.push_back(tbl[i]);
            tick();
            check("lat_valid_k", 32'(ser_valid), 0);
            check("lat_count_k", 32'(count), 1);
            check("lat_empty_k", 32'(empty), 0);
            res_done = 1'b0;
            tick();
            v = tbl[i].val;
            check("lat_valid_k1", 32'(ser_valid), 1);
            check("lat_first_bit", 32'(ser_data), 32'(v[WIDTH-1]));
            check("lat_frame_k1", 32'(ser_frame), 1);
            check("lat_count_k1", 32'(count), 0);
            wait_drain(40);
        end

        // Back-to-back frames separated by one idle cycle.
        pulse(11'h2A5, 1'b1);
        pulse(11'h15A, 1'b1);
        wait_drain(80);
        check("frame_gap", 32'(last_gap), 32'd2);

        // Backpressure after the third bit.
        v = 11'h2D9;
        res_val  = v;
        res_done = 1'b1;
        sb.push_back('{val: v, par: ^v});
        tick();
        res_done = 1'b0;
        n = 0;
        while (mon_idx < 3 && n < 20) begin
            tick();
            n++;
        end
        check("bp_reach_bit4", 32'(n < 20), 1);
        ser_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data", 32'(ser_data), 32'(v[WIDTH-4]));
            check("bp_hold_valid", 32'(ser_valid), 1);
            check("bp_hold_frame", 32'(ser_frame), 0);
        end
        ser_ready = 1'b1;
        wait_drain(40);

        // Overflow: first result parks in the shifter, next four fill the FIFO, sixth is dropped.
        ser_ready = 1'b0;
        for (int i = 1; i <= 5; i++)
            pulse(WIDTH'(i), 1'b1);
        check("ovf_count_full", 32'(count), 4);
        check("ovf_full", 32'(full), 1);
        check("ovf_not_yet", 32'(overflow), 0);
        pulse(11'd6, 1'b0);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count_hold", 32'(count), 4);
        clear_ovf = 1'b1;
        tick();
        check("ovf_cleared", 32'(overflow), 0);
        res_val   = 11'd7;
        res_done  = 1'b1;
        tick();
        check("ovf_set_wins", 32'(overflow), 1);
        res_done  = 1'b0;
        tick();
        check("ovf_cleared2", 32'(overflow), 0);
        clear_ovf = 1'b0;
        // Drain one frame, then push on the very edge the full FIFO pops.
        ser_ready = 1'b1;
        prev = frames_seen;
        n = 0;
        while (frames_seen == prev && n < 40) begin
            tick();
            n++;
        end
        check("ovf_first_frame", 32'(n < 40), 1);
        res_val  = 11'd8;
        res_done = 1'b1;
        sb.push_back('{val: 11'd8, par: ^11'd8});
        tick();
        check("full_pushpop_count", 32'(count), 4);
        check("full_pushpop_full", 32'(full), 1);
        check("full_pushpop_ovf", 32'(overflow), 0);
        res_done = 1'b0;
        wait_drain(200);

        // Done held high yields a single frame.
        prev     = frames_seen;
        res_val  = 11'h0F0;
        res_done = 1'b1;
        sb.push_back('{val: 11'h0F0, par: ^11'h0F0});
        repeat (10) tick();
        res_done = 1'b0;
        wait_drain(40);
        repeat (5) tick();
        check("held_done_frames", 32'(frames_seen - prev), 1);

        // Done already high across reset release yields nothing.
        prev     = frames_seen;
        res_val  = 11'h333;
        res_done = 1'b1;
        #2;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        res_done = 1'b0;
        repeat (20) tick();
        check("done_at_reset_frames", 32'(frames_seen - prev), 0);
        check("done_at_reset_empty", 32'(empty), 1);

        // Reset during bit 6 with two entries queued.
        pulse(11'h6B1, 1'b1);
        pulse(11'h123, 1'b1);
        pulse(11'h456, 1'b1);
        check("mid_queued", 32'(count), 2);
        check("mid_valid", 32'(ser_valid), 1);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_valid", 32'(ser_valid), 0);
        check("mid_rst_data", 32'(ser_data), 0);
        check("mid_rst_frame", 32'(ser_frame), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_full", 32'(full), 0);
        tick();
        reset = 1'b0;
        prev  = frames_seen;
        repeat (30) tick();
        check("mid_no_frame", 32'(frames_seen - prev), 0);
        check("mid_idle_valid", 32'(ser_valid), 0);

        check("sb_empty_at_end", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
